bus_frame_arbiter: RTL and testbench



---
 rtl/bus_frame_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bus_frame_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_frame_arbiter.sv
// Round-robin shared-bus master: grants one node, serialises its frame
// MSB first onto bus_show and re-checks the payload CRC on the fly.
module bus_frame_arbiter #(
    parameter int                N_NODES  = 16,
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 4,
    parameter int                CRC_W    = 4,
    parameter logic [CRC_W-1:0]  CRC_POLY = 4'b0011
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_NODES-1:0]           mod,
    input  logic [N_NODES*DATA_W-1:0]    Data,
    input  logic [N_NODES*ADDR_W-1:0]    receiverAddr,
    input  logic [N_NODES*CRC_W-1:0]     CRC,
    output logic [N_NODES-1:0]           ack,
    output logic                         busy,
    output logic [ADDR_W-1:0]            cur_src,
    output logic                         bus_show,
    output logic                         done,
    output logic                         crc_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

    typedef enum logic [2:0] {
        IDLE, START, SRC, DST, DATA, CRCF, STOP
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   ptr, winner, lo_win, hi_win;
    logic                hi_hit, grant, fb;
    logic [DATA_W-1:0]   sel_data, sh_data;
    logic [ADDR_W-1:0]   sel_dst, sh_src, sh_dst;
    logic [CRC_W-1:0]    sel_crc, sh_crc, crc_lat, acc;

    assign grant = (state == IDLE) && (|mod);
    assign busy  = (state != IDLE);
    assign fb    = acc[CRC_W-1] ^ sh_data[DATA_W-1];

    // Lowest request above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_hit = 1'b0;
        lo_win = '0;
        hi_win = '0;
        for (int i = N_NODES - 1; i >= 0; i--) begin
            if (mod[i]) begin
                lo_win = ADDR_W'(i);
                if (i > int'(ptr)) begin
                    hi_win = ADDR_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        winner = hi_hit ? hi_win : lo_win;
    end

    always_comb begin
        sel_data = '0;
        sel_dst  = '0;
        sel_crc  = '0;
        for (int i = 0; i < N_NODES; i++) begin
            if (winner == ADDR_W'(i)) begin
                sel_data = Data[i*DATA_W +: DATA_W];
                sel_dst  = receiverAddr[i*ADDR_W +: ADDR_W];
                sel_crc  = CRC[i*CRC_W +: CRC_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        bus_show  = 1'b0;
        done      = 1'b0;
        crc_err   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_nxt = START;
            end
            START: begin
                bus_show  = 1'b1;
                state_nxt = SRC;
            end
            SRC: begin
                bus_show = sh_src[ADDR_W-1];
                if (cnt == ADDR_LAST) state_nxt = DST;
                else cnt_nxt = cnt + 1'b1;
            end
            DST: begin
                bus_show = sh_dst[ADDR_W-1];
                if (cnt == ADDR_LAST) state_nxt = DATA;
                else cnt_nxt = cnt + 1'b1;
            end
            DATA: begin
                bus_show = sh_data[DATA_W-1];
                if (cnt == DATA_LAST) state_nxt = CRCF;
                else cnt_nxt = cnt + 1'b1;
            end
            CRCF: begin
                bus_show = sh_crc[CRC_W-1];
                if (cnt == CRC_LAST) state_nxt = STOP;
                else cnt_nxt = cnt + 1'b1;
            end
            STOP: begin
                done      = 1'b1;
                crc_err   = (acc != crc_lat);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow copies shift out MSB first; crc_lat stays intact for the check.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr     <= ADDR_W'(N_NODES - 1);
            cur_src <= '0;
            ack     <= '0;
            acc     <= '0;
            sh_src  <= '0;
            sh_dst  <= '0;
            sh_data <= '0;
            sh_crc  <= '0;
            crc_lat <= '0;
        end else begin
            ack <= '0;
            if (grant) begin
                ptr     <= winner;
                cur_src <= winner;
                ack     <= N_NODES'(1) << winner;
                acc     <= '0;
                sh_src  <= winner;
                sh_dst  <= sel_dst;
                sh_data <= sel_data;
                sh_crc  <= sel_crc;
                crc_lat <= sel_crc;
            end
            case (state)
                SRC:  sh_src <= sh_src << 1;
                DST:  sh_dst <= sh_dst << 1;
                DATA: begin
                    sh_data <= sh_data << 1;
                    acc     <= {acc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
                end
                CRCF: sh_crc <= sh_crc << 1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_frame_arbiter.sv
// Bench for bus_frame_arbiter: reference frames built from node inputs,
// round-robin order and CRC remainder taken from a reference model.
module tb_bus_frame_arbiter;

    localparam int N  = 16;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam int CW = 4;
    localparam int F  = 2 + 2*AW + DW + CW;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    mod;
    logic [N*DW-1:0] data_in;
    logic [N*AW-1:0] addr_in;
    logic [N*CW-1:0] crc_in;
    logic [N-1:0]    ack;
    logic            busy;
    logic [AW-1:0]   cur_src;
    logic            bus_show;
    logic            done;
    logic            crc_err;

    int tests = 0;
    int fails = 0;
    int ptr_m;

    always #5 clock = ~clock;

    bus_frame_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .mod          (mod),
        .Data         (data_in),
        .receiverAddr (addr_in),
        .CRC          (crc_in),
        .ack          (ack),
        .busy         (busy),
        .cur_src      (cur_src),
        .bus_show     (bus_show),
        .done         (done),
        .crc_err      (crc_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Remainder of data(x)*x^4 divided by x^4+x+1, by long division.
    function automatic logic [CW-1:0] crc_ref(input logic [DW-1:0] d);
        logic [DW+CW-1:0] v, g;
        v = {d, {CW{1'b0}}};
        for (int i = DW + CW - 1; i >= CW; i--) begin
            if (v[i]) begin
                g = '0;
                g[CW:0] = 5'b10011;
                v = v ^ (g << (i - CW));
            end
        end
        return v[CW-1:0];
    endfunction

    function automatic int rr_pick(input int p, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic randomize_nodes();
        for (int i = 0; i < N; i++) begin
            data_in[i*DW +: DW] = {$urandom, $urandom};
            addr_in[i*AW +: AW] = AW'($urandom);
            crc_in[i*CW +: CW]  = CW'($urandom);
            if ($urandom_range(0, 1) == 1)
                crc_in[i*CW +: CW] = crc_ref(data_in[i*DW +: DW]);
        end
    endtask

    task automatic wait_grant(output int w);
        w = 0;
        forever begin
            @(negedge clock);
            if (ack != '0) return;
            w++;
            if (w > 300) begin
                chk("grant_timeout", 64'd1, 64'd0);
                w = -1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_outs", {ack, busy, bus_show, done, crc_err}, 64'd0);
        chk("rst_src", cur_src, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        ptr_m = N - 1;
    endtask

    task automatic frame(input int abort_at, input logic [N-1:0] mod_mid);
        int w, win, idx;
        logic [DW-1:0] d;
        logic [AW-1:0] a, s;
        logic [CW-1:0] c4;
        logic err;
        logic [N-1:0] oh;
        logic eb [F];
        win = rr_pick(ptr_m, mod);
        wait_grant(w);
        if (w < 0) return;
        chk("gap", w, 64'd0);
        d   = data_in[win*DW +: DW];
        a   = addr_in[win*AW +: AW];
        c4  = crc_in[win*CW +: CW];
        err = (crc_ref(d) != c4);
        s   = AW'(win);
        ptr_m = win;
        oh = '0;
        oh[win] = 1'b1;
        idx = 0;
        eb[idx] = 1'b1;
        idx++;
        for (int b = AW - 1; b >= 0; b--) begin eb[idx] = s[b]; idx++; end
        for (int b = AW - 1; b >= 0; b--) begin eb[idx] = a[b]; idx++; end
        for (int b = DW - 1; b >= 0; b--) begin eb[idx] = d[b]; idx++; end
        for (int b = CW - 1; b >= 0; b--) begin eb[idx] = c4[b]; idx++; end
        eb[idx] = 1'b0;
        for (int c = 1; c <= F; c++) begin
            if (c > 1) @(negedge clock);
            if (abort_at == c) begin
                reset = 1'b1;
                #1;
                chk("abort_outs", {ack, busy, bus_show, done, crc_err}, 64'd0);
                chk("abort_src", cur_src, 64'd0);
                return;
            end
            chk($sformatf("bus_show[%0d]", c), bus_show, eb[c-1]);
            chk("busy", busy, 64'd1);
            chk("done", done, (c == F));
            chk("crc_err", crc_err, (c == F) && err);
            chk("ack", ack, (c == 1) ? oh : '0);
            chk("cur_src", cur_src, win);
            if (c == 20) begin
                randomize_nodes();
                mod = mod_mid;
            end
        end
        @(negedge clock);
        chk("idle", {ack, busy, bus_show, done, crc_err}, 64'd0);
    endtask

    initial begin
        logic [N-1:0] m;
        reset = 1'b1;
        mod   = '0;
        ptr_m = N - 1;
        randomize_nodes();
        @(negedge clock);
        chk("reset_outs", {ack, busy, bus_show, done, crc_err}, 64'd0);
        chk("reset_src", cur_src, 64'd0);

        // Node 0, payload 1: computed CRC 3 differs from supplied 1.
        data_in[0 +: DW] = 64'd1;
        addr_in[0 +: AW] = 4'd1;
        crc_in[0 +: CW]  = 4'd1;
        mod = 16'h0001;
        reset = 1'b0;
        frame(0, 16'h0001);

        data_in[0 +: DW] = 64'd1;
        addr_in[0 +: AW] = 4'd1;
        crc_in[0 +: CW]  = 4'd3;
        frame(0, 16'h0001);

        mod = 16'h0003;
        do_reset();
        repeat (4) frame(0, 16'h0003);

        mod = 16'h8001;
        do_reset();
        repeat (4) frame(0, 16'h8001);

        mod = 16'h0001;
        do_reset();
        frame(40, 16'h0001);
        mod = 16'hFFFF;
        ptr_m = N - 1;
        @(negedge clock);
        reset = 1'b0;
        frame(0, 16'hFFFF);

        for (int k = 0; k < 6; k++) begin
            m = N'($urandom);
            if (m == '0) m = 16'h0400;
            frame(0, m);
        end

        mod = '0;
        do_reset();
        repeat (200) begin
            @(negedge clock);
            chk("quiet", {ack, busy, bus_show, done, crc_err}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
